// File: rtl/rv_plic_core_pkg.sv
// Shared types and packed-vector index helpers for the PLIC core.
package rv_plic_core_pkg;

   typedef enum logic [1:0] {
      GW_IDLE    = 2'd0,
      GW_PENDING = 2'd1,
      GW_ACTIVE  = 2'd2
   } gw_state_e;

   // LSB position of element idx in a vector of width-wide fields
   function automatic int slice_lsb(input int idx, input int width);
      return idx * width;
   endfunction

   // Bit position of (row, col) in a row-major packed matrix with ncol columns
   function automatic int flat_idx(input int row, input int col, input int ncol);
      return row * ncol + col;
   endfunction

endpackage

// File: rtl/rv_plic_core_gateway.sv
// One interrupt source: level/edge/MSI event capture, pending/claim state
// machine and a saturating count of edges that arrive while the source is busy.
module rv_plic_core_gateway
   import rv_plic_core_pkg::*;
#(
   parameter int EdgeCntW = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic src_i,
   input  logic le_i,
   input  logic msi_i,
   input  logic claim_i,
   input  logic complete_i,
   output logic ip_o,
   output logic ovf_o
);
   // state      | meaning
   // GW_IDLE    | no request outstanding
   // GW_PENDING | request visible to arbitration (ip set)
   // GW_ACTIVE  | claimed by a target, waiting for complete

   localparam logic [EdgeCntW-1:0] CntMax = '1;

   gw_state_e           state_q, state_mid;
   logic [EdgeCntW-1:0] cnt_q, cnt_mid;
   logic                src_q;
   logic                edge_ev, level_ev;

   assign edge_ev  = msi_i | (le_i & src_i & ~src_q);
   assign level_ev = ~le_i & src_i;

   // claim/complete resolve first; this cycle's event is applied on top
   always_comb begin
      state_mid = state_q;
      cnt_mid   = cnt_q;
      case (state_q)
         GW_PENDING: if (claim_i) state_mid = GW_ACTIVE;
         GW_ACTIVE: begin
            if (complete_i) begin
               if (cnt_q == '0) begin
                  state_mid = GW_IDLE;
               end else begin
                  state_mid = GW_PENDING;
                  cnt_mid   = cnt_q - EdgeCntW'(1);
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= GW_IDLE;
         cnt_q   <= '0;
         src_q   <= 1'b0;
         ovf_o   <= 1'b0;
      end else begin
         src_q   <= src_i;
         state_q <= state_mid;
         cnt_q   <= cnt_mid;
         if (state_mid == GW_IDLE) begin
            if (edge_ev | level_ev) state_q <= GW_PENDING;
         end else if (edge_ev) begin
            if (cnt_mid == CntMax) ovf_o <= 1'b1;
            else                   cnt_q <= cnt_mid + EdgeCntW'(1);
         end
      end
   end

   assign ip_o = (state_q == GW_PENDING);

endmodule

// File: rtl/rv_plic_core.sv
// PLIC datapath core: per-source gateways, claim/complete routing and
// registered per-target priority arbitration.
module rv_plic_core
   import rv_plic_core_pkg::*;
#(
   parameter int NumSrc    = 128,
   parameter int NumTarget = 4,
   parameter int PrioW     = 3,
   parameter int EdgeCntW  = 4,
   parameter int SrcW      = $clog2(NumSrc)
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [NumSrc-1:0]             intr_src_i,
   input  logic [NumSrc-1:0]             le_i,
   input  logic                          msi_valid_i,
   input  logic [SrcW-1:0]               msi_id_i,
   input  logic [NumSrc*PrioW-1:0]       prio_i,
   input  logic [NumTarget*NumSrc-1:0]   ie_i,
   input  logic [NumTarget*PrioW-1:0]    threshold_i,
   input  logic [NumTarget-1:0]          claim_i,
   input  logic [NumTarget-1:0]          complete_i,
   input  logic [NumTarget*SrcW-1:0]     complete_id_i,
   output logic [NumSrc-1:0]             ip_o,
   output logic [NumSrc-1:0]             ovf_o,
   output logic [NumTarget-1:0]          irq_o,
   output logic [NumTarget*SrcW-1:0]     irq_id_o
);

   logic [NumSrc-1:1] claim_hit, complete_hit, msi_hit;
   logic [PrioW-1:0]  best_prio [NumTarget];
   logic [SrcW-1:0]   best_id   [NumTarget];
   logic              unused_src0;

   // source 0 is reserved and never raises a request
   assign unused_src0 = intr_src_i[0] ^ le_i[0];
   assign ip_o[0]     = 1'b0;
   assign ovf_o[0]    = 1'b0;

   always_comb begin
      claim_hit    = '0;
      complete_hit = '0;
      msi_hit      = '0;
      for (int s = 1; s < NumSrc; s++) begin
         msi_hit[s] = msi_valid_i && (msi_id_i == SrcW'(s));
         for (int t = 0; t < NumTarget; t++) begin
            if (claim_i[t] && (irq_id_o[slice_lsb(t, SrcW) +: SrcW] == SrcW'(s)))
               claim_hit[s] = 1'b1;
            if (complete_i[t] && (complete_id_i[slice_lsb(t, SrcW) +: SrcW] == SrcW'(s)))
               complete_hit[s] = 1'b1;
         end
      end
   end

   for (genvar s = 1; s < NumSrc; s++) begin : g_gw
      rv_plic_core_gateway #(
         .EdgeCntW(EdgeCntW)
      ) u_gw (
         .clk_i      (clk_i),
         .rst_i      (rst_i),
         .src_i      (intr_src_i[s]),
         .le_i       (le_i[s]),
         .msi_i      (msi_hit[s]),
         .claim_i    (claim_hit[s]),
         .complete_i (complete_hit[s]),
         .ip_o       (ip_o[s]),
         .ovf_o      (ovf_o[s])
      );
   end

   // strict greater-than while scanning upward gives ties to the lowest ID
   always_comb begin
      for (int t = 0; t < NumTarget; t++) begin
         best_prio[t] = '0;
         best_id[t]   = '0;
         for (int s = 0; s < NumSrc; s++) begin
            if (ip_o[s] && ie_i[flat_idx(t, s, NumSrc)] &&
                (prio_i[slice_lsb(s, PrioW) +: PrioW] > best_prio[t])) begin
               best_prio[t] = prio_i[slice_lsb(s, PrioW) +: PrioW];
               best_id[t]   = SrcW'(s);
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         irq_o    <= '0;
         irq_id_o <= '0;
      end else begin
         for (int t = 0; t < NumTarget; t++) begin
            irq_o[t] <= best_prio[t] > threshold_i[slice_lsb(t, PrioW) +: PrioW];
            irq_id_o[slice_lsb(t, SrcW) +: SrcW] <= best_id[t];
         end
      end
   end

endmodule
